pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//   PC generation and fetch-control stage feeding instruction_fetch. Holds the PC
//   register and selects the next PC (sequential, redirect or stall).
//   Compensates for the 1-cycle registered read latency of the instruction BRAM.
//   Delivers {if_pc, if_instr, if_valid} to the IF/ID register, with a skid buffer
//   for stalls and bubble insertion after a redirect.
// PARAMETERS
//   RESET_PC     32'h0000_0000   PC value loaded on reset; must be 4-byte aligned
//   PC_WIDTH     `PC_WIDTH (32)  PC / instruction width
//   IADDR_WIDTH  `IADDR_WIDTH    word-address width of instruction BRAM
// PORTS
//   clk             in   1            system clock, all state on rising edge
//   rst             in   1            synchronous active-high reset
//   stall           in   1            hazard unit: hold PC and IF outputs
//   redirect_valid  in   1            EX: taken branch/jump this cycle
//   redirect_pc     in   PC_WIDTH     EX: redirect target (byte address)
//   imem_addr       out  IADDR_WIDTH  word address to BRAM (via instruction_fetch)
//   imem_rdata      in   PC_WIDTH     BRAM dout, valid 1 cycle after imem_addr
//   if_pc           out  PC_WIDTH     PC of the instruction on if_instr
//   if_instr        out  PC_WIDTH     fetched instruction
//   if_valid        out  1            if_instr/if_pc are a real instruction
//   fetch_cnt       out  32           count of instructions accepted downstream
//   bubble_cnt      out  32           count of cycles with if_valid=0 (not in rst)
// BEHAVIOUR
//   Reset: pc_q=RESET_PC, if_pc=0, if_valid=0, skid=0, state=BUBBLE, counters=0.
//   Next PC, priority high->low:
//     redirect_valid -> pc_q <= redirect_pc & `PC_ALIGNED_MASK (low 2 bits dropped)
//     stall          -> pc_q holds
//     else           -> pc_q <= pc_q + 4, mod 2^PC_WIDTH (0xFFFF_FFFC -> 0)
//   imem_addr = instruction_fetch(pc_q): combinational, same cycle as pc_q.
//   Address issued in cycle t: data on imem_rdata in t+1.
//   if_pc_q <= pc_q whenever PC advances or redirects. It tracks the BRAM latency.
//   States:
//     BUBBLE: if_valid=0. Output is stale or killed. Next state RUN unless
//             redirect_valid (stay in BUBBLE) or stall (stay in BUBBLE, PC held).
//     RUN:    if_instr=imem_rdata, if_valid=1.
//             stall & !redirect -> skid<=imem_rdata, go to HOLD.
//             redirect -> BUBBLE.
//     HOLD:   if_instr=skid, if_pc and if_valid held.
//             !stall -> RUN: the BRAM now returns the held PC's word.
//             redirect -> BUBBLE.
//   Redirect:
//     - The cycle after a redirect is always a bubble: exactly 1 lost slot.
//     - if_valid is 0 combinationally in any cycle where redirect_valid=1,
//       which kills the wrong-path instruction.
//   Simultaneous redirect+stall: redirect wins; PC loads the target; state BUBBLE.
//   Reset mid-operation (any state): returns to the reset values next edge.
//     First valid instruction appears 2 cycles after rst deasserts.
//   Counters:
//     fetch_cnt  += 1 when if_valid & !stall.
//     bubble_cnt += 1 when !if_valid & !rst.
//     Both wrap at 2^32.
// STRUCTURE
//   Shared define.vh: PC_WIDTH, IADDR_WIDTH, PC_ALIGNED_MASK, RESET_PC default,
//   state encodings FS_BUBBLE/FS_RUN/FS_HOLD (2-bit).
//   Sub-module: instruction_fetch instantiated unchanged, generating imem_addr.
//   Remainder: PC reg, next-PC mux, state FSM, skid reg, if_pc reg, 2 counters.
//   BRAM model in the bench: 1-cycle registered read.
// TESTING
//   1 Reset, then release, no stall. BRAM word n = 0x1000+n.
//     -> if_valid=0 for 1 cycle after rst falls; if_pc 0,4,8.. with if_instr
//        0x1000,0x1001.. one per cycle.
//   2 Stall 3 cycles while if_pc=0x8.
//     -> if_pc=0x8 and if_instr=0x1002 held all 3 cycles. First cycle after:
//        if_pc=0xC, if_instr=0x1003. No duplicates or skips. fetch_cnt +1 for 0x8.
//   3 Redirect to 0x40 while if_pc=0x10.
//     -> if_valid=0 that cycle and the next. Then if_pc=0x40, if_instr=0x1010.
//        bubble_cnt +2.
//   4 Redirect and stall in the same cycle, target 0x22.
//     -> pc_q=0x20, imem_addr=0x8, state BUBBLE; stall ignored.
//        Next valid if_pc=0x20.
//   5 RESET_PC=0xFFFF_FFF8, run 4 cycles.
//     -> if_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0: PC wraps cleanly.
//   6 rst asserted in HOLD.
//     -> next cycle if_valid=0, pc_q=RESET_PC, skid=0, counters=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the PC generation / fetch-control stage.
// Sized defaults are consumed as parameter defaults by the top and the address generator.
package pc_fetch_ctrl_pkg;

    localparam int          PC_WIDTH_DEF    = 32;
    localparam int          IADDR_WIDTH_DEF = 10;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGNED_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FS_BUBBLE = 2'd0,
        FS_RUN    = 2'd1,
        FS_HOLD   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_instruction_fetch.sv
// Maps a byte-addressed PC onto the word address of the instruction BRAM.
// Purely combinational: the address is valid in the same cycle as the PC.
module instruction_fetch
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int IADDR_WIDTH = IADDR_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [IADDR_WIDTH-1:0] imem_addr_o
);

    // Byte offset and bits beyond the BRAM depth do not select a word.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[PC_WIDTH-1:IADDR_WIDTH+2], pc_i[1:0]};

    assign imem_addr_o = pc_i[IADDR_WIDTH+1:2];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, next-PC selection and fetch FSM with skid buffer in front of the IF/ID register.
// Compensates for the one-cycle registered read latency of the instruction BRAM.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  IADDR_WIDTH = IADDR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [IADDR_WIDTH-1:0] imem_addr,
    input  logic [PC_WIDTH-1:0]    imem_rdata,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [PC_WIDTH-1:0]    if_instr,
    output logic                   if_valid,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            bubble_cnt
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [PC_WIDTH-1:0] skid_q, skid_d;
    fetch_state_e        state_q, state_d;
    logic [31:0]         fetch_cnt_q, fetch_cnt_d;
    logic [31:0]         bubble_cnt_q, bubble_cnt_d;

    instruction_fetch #(
        .PC_WIDTH    (PC_WIDTH),
        .IADDR_WIDTH (IADDR_WIDTH)
    ) u_instruction_fetch (
        .pc_i        (pc_q),
        .imem_addr_o (imem_addr)
    );

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path can infer a latch.
        pc_d     = pc_q;
        if_pc_d  = if_pc_q;
        skid_d   = skid_q;
        state_d  = state_q;
        if_valid = 1'b0;
        if_instr = imem_rdata;

        // if_pc trails pc by one cycle, matching the BRAM read latency.
        if (redirect_valid) begin
            pc_d    = redirect_pc & PC_WIDTH'(PC_ALIGNED_MASK);
            if_pc_d = pc_q;
        end else if (!stall) begin
            pc_d    = pc_q + PC_WIDTH'(4);
            if_pc_d = pc_q;
        end

        unique case (state_q)
            FS_BUBBLE: begin
                if (!redirect_valid && !stall) state_d = FS_RUN;
            end
            FS_RUN: begin
                if_valid = 1'b1;
                if (redirect_valid) begin
                    state_d = FS_BUBBLE;
                end else if (stall) begin
                    skid_d  = imem_rdata;
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if_valid = 1'b1;
                if_instr = skid_q;
                if (redirect_valid)  state_d = FS_BUBBLE;
                else if (!stall)     state_d = FS_RUN;
            end
            default: state_d = FS_BUBBLE;
        endcase

        // The instruction on the output this cycle is on the wrong path.
        if (redirect_valid) if_valid = 1'b0;

        fetch_cnt_d  = fetch_cnt_q  + 32'(if_valid && !stall);
        bubble_cnt_d = bubble_cnt_q + 32'(!if_valid);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            pc_q         <= RESET_PC;
            if_pc_q      <= '0;
            skid_q       <= '0;
            state_q      <= FS_BUBBLE;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            skid_q       <= skid_d;
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign if_pc      = if_pc_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
